// File: rtl/tpu_cmd_pkg.sv
// Shared constants for the TPU command controller: register offsets, bit positions,
// AXI response codes, the sequencer state enum and a byte-lane merge helper.
package tpu_cmd_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_CMD    = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_ARG    = 4'hC;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] result;
    result = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) result[8*i +: 8] = new_val[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/tpu_cmd_ctrl_if.sv
// AXI4-Lite slave bus plus the command channel to the TPU core and the interrupt line.
interface tpu_cmd_ctrl_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [7:0]                      cmd_opcode;
  logic [31:0]                     cmd_arg;
  logic                            core_done;
  logic                            irq;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
           cmd_ready, core_done,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, cmd_valid, cmd_opcode, cmd_arg, irq
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
           cmd_ready, core_done,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, cmd_valid, cmd_opcode, cmd_arg, irq
  );
endinterface

// File: rtl/tpu_cmd_fsm.sv
// Command sequencer: issues the latched command N times, waiting for core_done between issues.
module tpu_cmd_fsm
  import tpu_cmd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_repeat,
  input  logic       i_cmd_ready,
  input  logic       i_core_done,
  output logic       o_cmd_valid,
  output state_e     o_state,
  output logic [7:0] o_issued
);

  state_e     r_state;
  logic [7:0] r_repeat;
  logic [7:0] r_issued;
  logic       r_cmd_valid;

  // Sequencer state, repeat target, issued counter and registered cmd_valid
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_repeat    <= 8'd0;
      r_issued    <= 8'd0;
      r_cmd_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state     <= ST_ISSUE;
            r_repeat    <= (i_repeat == 8'd0) ? 8'd1 : i_repeat;
            r_issued    <= 8'd0;
            r_cmd_valid <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (r_cmd_valid && i_cmd_ready) begin
            r_issued    <= r_issued + 8'd1;
            r_cmd_valid <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // core_done only counts here; in IDLE/ISSUE it is ignored
          if (i_core_done) begin
            if (r_issued < r_repeat) begin
              r_state     <= ST_ISSUE;
              r_cmd_valid <= 1'b1;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd_valid = r_cmd_valid;
  assign o_state     = r_state;
  assign o_issued    = r_issued;

endmodule

// File: rtl/tpu_cmd_ctrl.sv
// AXI4-Lite register front-end for the TPU command sequencer.
// Define TPU_CMD_CTRL_IRQ_EN to build the IRQ_EN bit and the irq output.
module tpu_cmd_ctrl
  import tpu_cmd_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input logic           ACLK,
  input logic           ARESET,
  tpu_cmd_ctrl_if.slave bus
);

  logic                          r_awready, r_bvalid, r_arready, r_rvalid, r_done;
  logic [1:0]                    r_bresp, r_rresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata, w_rd_data;
  logic [15:0]                   r_cmd;
  logic [31:0]                   r_arg, w_cmd_merged;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_awaddr, w_araddr;
  logic [1:0]                    w_wr_idx;
  logic                          w_wr_en, w_wr_err, w_start_bit, w_start, w_busy;
  logic                          w_w1c_done, w_irq_en, w_cmd_valid, w_unused;
  logic [7:0]                    w_issued;
  state_e                        w_state;

  assign w_awaddr     = bus.S_AXI_AWADDR;
  assign w_araddr     = bus.S_AXI_ARADDR;
  assign w_wr_idx     = w_awaddr[3:2];
  assign w_wr_en      = r_awready && bus.S_AXI_AWVALID && bus.S_AXI_WVALID;
  assign w_busy       = (w_state != ST_IDLE);
  assign w_start_bit  = (w_wr_idx == OFF_CTRL[3:2]) && bus.S_AXI_WSTRB[0]
                        && bus.S_AXI_WDATA[CTRL_START_BIT];
  assign w_start      = w_wr_en && w_start_bit && !w_busy;
  assign w_w1c_done   = w_wr_en && (w_wr_idx == OFF_STATUS[3:2]) && bus.S_AXI_WSTRB[0]
                        && bus.S_AXI_WDATA[STATUS_DONE_BIT];
  assign w_cmd_merged = apply_wstrb({16'h0000, r_cmd}, bus.S_AXI_WDATA, bus.S_AXI_WSTRB);
  assign w_unused     = ^{bus.S_AXI_AWPROT, bus.S_AXI_ARPROT, w_awaddr[1:0], w_araddr[1:0],
                          w_cmd_merged[31:16]};

  // Writes that would disturb a running sequence are rejected
  always_comb begin
    w_wr_err = 1'b0;
    case (w_wr_idx)
      OFF_CTRL[3:2]:                w_wr_err = w_start_bit && w_busy;
      OFF_CMD[3:2], OFF_ARG[3:2]:   w_wr_err = w_busy;
      default:                      w_wr_err = 1'b0;
    endcase
  end

  // Write address/data acceptance and write response channel
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_awready <= bus.S_AXI_AWVALID && bus.S_AXI_WVALID && !r_bvalid && !r_awready;
      if (w_wr_en) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_bvalid && bus.S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // CMD/ARG storage and the DONE flag (set wins over W1C)
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cmd  <= 16'h0000;
      r_arg  <= 32'h0000_0000;
      r_done <= 1'b0;
    end else begin
      if (w_wr_en && !w_wr_err) begin
        case (w_wr_idx)
          OFF_CMD[3:2]: r_cmd <= w_cmd_merged[15:0];
          OFF_ARG[3:2]: r_arg <= apply_wstrb(r_arg, bus.S_AXI_WDATA, bus.S_AXI_WSTRB);
          default:      ;
        endcase
      end
      if (w_state == ST_DONE)       r_done <= 1'b1;
      else if (w_start || w_w1c_done) r_done <= 1'b0;
    end
  end

`ifdef TPU_CMD_CTRL_IRQ_EN
  logic r_irq_en, r_irq;

  // Interrupt enable bit and registered level interrupt
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_en && !w_wr_err && (w_wr_idx == OFF_CTRL[3:2]) && bus.S_AXI_WSTRB[0])
        r_irq_en <= bus.S_AXI_WDATA[CTRL_IRQ_EN_BIT];
      r_irq <= r_done && r_irq_en;
    end
  end

  assign w_irq_en = r_irq_en;
  assign bus.irq  = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign bus.irq  = 1'b0;
`endif

  always_comb begin
    w_rd_data = {C_S_AXI_DATA_WIDTH{1'b0}};
    case (w_araddr[3:2])
      OFF_CTRL[3:2]:   w_rd_data = {30'h0, w_irq_en, 1'b0};
      OFF_CMD[3:2]:    w_rd_data = {16'h0000, r_cmd};
      OFF_STATUS[3:2]: w_rd_data = {16'h0000, w_issued, 6'h00, r_done, w_busy};
      OFF_ARG[3:2]:    w_rd_data = r_arg;
      default:         w_rd_data = {C_S_AXI_DATA_WIDTH{1'b0}};
    endcase
  end

  // Read address acceptance and read data channel
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= {C_S_AXI_DATA_WIDTH{1'b0}};
      r_rresp   <= RESP_OKAY;
    end else begin
      r_arready <= bus.S_AXI_ARVALID && !r_rvalid && !r_arready;
      if (r_arready && bus.S_AXI_ARVALID) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= RESP_OKAY;
      end else if (r_rvalid && bus.S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  tpu_cmd_fsm u_fsm (
    .i_clk       (ACLK),
    .i_rst       (ARESET),
    .i_start     (w_start),
    .i_repeat    (r_cmd[15:8]),
    .i_cmd_ready (bus.cmd_ready),
    .i_core_done (bus.core_done),
    .o_cmd_valid (w_cmd_valid),
    .o_state     (w_state),
    .o_issued    (w_issued)
  );

  assign bus.S_AXI_AWREADY = r_awready;
  assign bus.S_AXI_WREADY  = r_awready;
  assign bus.S_AXI_BVALID  = r_bvalid;
  assign bus.S_AXI_BRESP   = r_bresp;
  assign bus.S_AXI_ARREADY = r_arready;
  assign bus.S_AXI_RVALID  = r_rvalid;
  assign bus.S_AXI_RDATA   = r_rdata;
  assign bus.S_AXI_RRESP   = r_rresp;
  assign bus.cmd_valid     = w_cmd_valid;
  assign bus.cmd_opcode    = r_cmd[7:0];
  assign bus.cmd_arg       = r_arg;

endmodule

// File: doc/tpu_cmd_ctrl.md
TPU_CMD_CTRL -- requirements
Module: tpu_cmd_ctrl

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, meaning byte address width (4 registers).
REQ-003 SHALL have ports:
- ACLK  in  1  single clock.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  4/3/1/1  write address channel.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  4/3/1/1  read address channel.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel.
- cmd_valid/cmd_ready  out/in  1/1  command handshake to TPU core.
- cmd_opcode  out  8  opcode.
- cmd_arg  out  32  argument.
- core_done  in  1  one-cycle pulse when the core finishes the accepted command.
- irq  out  1  level interrupt.

Function
REQ-004 SHALL decode register index from address bits [3:2]: 0x0 CTRL, 0x4 CMD, 0x8 STATUS, 0xC ARG.
- CTRL bit0 START: write-1, self-clearing, reads 0.
- CTRL bit1 IRQ_EN: read/write.
- CMD [7:0] opcode; CMD [15:8] repeat count N (N=0 treated as 1).
- STATUS bit0 BUSY (RO); bit1 DONE (W1C); [15:8] issued count (RO).
- ARG: 32-bit read/write.
REQ-005 SHALL accept a write only when AWVALID and WVALID are both high and BVALID is low, asserting AWREADY and WREADY together for exactly one cycle.
REQ-006 SHALL assert BVALID the cycle after write acceptance and hold it until BREADY.
REQ-007 SHALL apply WSTRB per byte lane for CTRL/CMD/ARG writes.
REQ-008 SHALL respond BRESP=SLVERR (2'b10) and leave register contents unchanged for:
- a write to CMD or ARG while BUSY.
- a write of START=1 while BUSY.
All other writes SHALL respond OKAY.
REQ-009 SHALL assert ARREADY for one cycle when ARVALID is high and RVALID is low, then drive RVALID with RDATA/RRESP=OKAY on the next cycle and hold all three until RREADY.
REQ-010 SHALL run an FSM with states IDLE, ISSUE, WAIT, DONE:
- IDLE -> ISSUE on an accepted START, latching N and clearing the issued count and DONE.
- ISSUE: drive cmd_valid=1 with opcode/ARG; on cmd_valid&&cmd_ready, increment the issued count and go to WAIT.
- WAIT: on core_done, go to ISSUE if issued count < N, else to DONE.
- DONE: set DONE for one cycle, then go to IDLE.
REQ-011 SHALL keep cmd_opcode and cmd_arg stable while cmd_valid is high, and SHALL NOT drop cmd_valid before cmd_ready.
REQ-012 SHALL report BUSY=1 in ISSUE, WAIT and DONE.
REQ-013 SHALL ignore core_done in IDLE and ISSUE.
REQ-014 SHALL give the set priority when a DONE W1C write and the DONE set occur in the same cycle (DONE=1).
REQ-015 SHALL drive irq = DONE && IRQ_EN, registered.

Reset
REQ-016 SHALL, on ARESET=1 at a rising ACLK edge:
- set FSM state to IDLE and clear all registers and counts.
- drive all READY/VALID outputs and irq to 0, RDATA to 0, and BRESP/RRESP to OKAY.
REQ-017 SHALL abandon any in-flight command or AXI transaction when reset occurs mid-operation, with no response issued afterwards.

Configuration
REQ-018 SHALL compile the interrupt path only when TPU_CMD_CTRL_IRQ_EN is defined.
- Without the macro: irq is tied to 0, CTRL bit1 reads 0, and writes to it are ignored.
- The DONE bit behaves identically with or without the macro.

Structure
REQ-019 SHALL place register offsets, CTRL/STATUS bit positions, response codes and the FSM state enum in the shared package tpu_cmd_pkg.
REQ-020 SHALL be partitioned into the AXI4-Lite register interface plus one sub-module, tpu_cmd_fsm, holding the sequencing FSM and issued counter.

Verification
REQ-021 Reset then read all four registers -> RDATA 0x0 each, RRESP OKAY.
REQ-022 Write ARG=0xDEADBEEF, CMD=0x0000_0305, START -> three cmd_valid handshakes, each with opcode 0x05 and arg 0xDEADBEEF; STATUS reads 0x0000_0302 after the third core_done.
REQ-023 Hold cmd_ready=0 for 10 cycles during ISSUE -> cmd_valid stays 1 and outputs stay stable; exactly one handshake when cmd_ready rises.
REQ-024 Write ARG=0x1234 while BUSY -> BRESP SLVERR and ARG retains its old value; START while BUSY -> SLVERR and no extra command is issued.
REQ-025 With IRQ_EN=1, complete a run, then write 0x2 to STATUS -> irq rises after DONE and falls one cycle after the W1C write; with the macro undefined, irq stays 0 throughout.
REQ-026 Assert ARESET during WAIT -> next cycle: FSM IDLE, BUSY=0, cmd_valid=0; a later core_done pulse causes no state change.
